sec_encoder_awe_28bits_clk: RTL and testbench

//  Sequential AN-code encoder, the transmit-side partner of the 28-bit SEC AWE decoder.

---
 rtl/sec_encoder_awe_28bits_clk.sv | 101 ++++++++++
 tb/tb_sec_encoder_awe_28bits_clk.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sec_encoder_awe_28bits_clk.sv
// sec_encoder_awe_28bits_clk: sequential AN-code encoder (W = A_CONST*N) with optional single arithmetic error injection
module sec_encoder_awe_28bits_clk #(
    parameter int          N_BITS  = 28,
    parameter int          W_BITS  = 36,
    parameter int unsigned A_CONST = 167
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N,
    input  logic              err_en,
    input  logic              err_sign,
    input  logic [5:0]        err_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic              busy
);
    localparam int A_BITS = W_BITS - N_BITS;
    localparam int CW = A_BITS > 1 ? $clog2(A_BITS) : 1;
    localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A_CONST);
    localparam logic [W_BITS-1:0] ONE = {{(W_BITS-1){1'b0}}, 1'b1};

    if (A_CONST % 2 == 0 || A_CONST >= (64'd1 << A_BITS) || W_BITS <= N_BITS) begin : g_bad_params
        $error("sec_encoder_awe_28bits_clk: A_CONST must be odd and below 2^A_BITS, W_BITS must exceed N_BITS");
    end

    typedef enum logic [1:0] {IDLE, MUL, ERR, OUT} state_t;

    state_t            state, state_n;
    logic [N_BITS-1:0] n_q;
    logic              err_en_q, err_sign_q, err_hit;
    logic [5:0]        err_pos_q;
    logic [CW-1:0]     cnt;
    logic [W_BITS-1:0] acc, addend, delta, acc_err;

    assign in_ready = (state == IDLE) & ~rst;
    assign busy     = state != IDLE;

    // partial product for the current multiplier bit and the error-adjusted accumulator
    always_comb begin
        addend  = A_VEC[cnt] ? ({{A_BITS{1'b0}}, n_q} << cnt) : '0;
        err_hit = err_en_q && (int'(err_pos_q) < W_BITS);
        delta   = ONE << err_pos_q;
        acc_err = err_hit ? (err_sign_q ? acc - delta : acc + delta) : acc;
    end

    // state register; reset discards any in-flight word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state: one MUL step per bit of A_CONST, one ERR step, then hold until taken
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = (in_valid && in_ready) ? MUL : IDLE;
            MUL:  state_n = (cnt == CW'(A_BITS - 1)) ? ERR : MUL;
            ERR:  state_n = OUT;
            OUT:  state_n = out_ready ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end

    // datapath: latch inputs on accept, shift-add, publish codeword, clear valid on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= '0;
            err_en_q   <= 1'b0;
            err_sign_q <= 1'b0;
            err_pos_q  <= '0;
            cnt        <= '0;
            acc        <= '0;
            W          <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    n_q        <= N;
                    err_en_q   <= err_en;
                    err_sign_q <= err_sign;
                    err_pos_q  <= err_pos;
                    acc        <= '0;
                    cnt        <= '0;
                end
                MUL: begin
                    acc <= acc + addend;
                    cnt <= cnt + 1'b1;
                end
                ERR: begin
                    W         <= acc_err;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sec_encoder_awe_28bits_clk.sv
// tb_sec_encoder_awe_28bits_clk: directed checks of the AN-code encoder
module tb_sec_encoder_awe_28bits_clk;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, err_en = 1'b0, err_sign = 1'b0, out_ready = 1'b0;
    logic [27:0] N = '0;
    logic [5:0]  err_pos = '0;
    logic        in_ready, out_valid, busy;
    logic [35:0] W;
    int          total = 0, bad = 0;

    sec_encoder_awe_28bits_clk dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .N(N),
        .err_en(err_en), .err_sign(err_sign), .err_pos(err_pos),
        .out_valid(out_valid), .out_ready(out_ready), .W(W), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] model(input logic [27:0] n, input logic en, input logic sgn, input logic [5:0] pos);
        logic [63:0] p;
        p = 64'd167 * 64'(n);
        if (en && pos < 6'd36) p = sgn ? p - (64'd1 << pos) : p + (64'd1 << pos);
        return p[35:0];
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!in_ready && k < 30) begin @(posedge clk); #1; k++; end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic send(input string tag, input logic [27:0] n, input logic en, input logic sgn,
                        input logic [5:0] pos, input logic [35:0] exp, input logic early);
        int k = 0;
        wait_ready(tag);
        N = n; err_en = en; err_sign = sgn; err_pos = pos; in_valid = 1'b1; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0; N = ~n; err_en = ~en; err_pos = ~pos;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        chk({tag, "_latency"}, 64'(k), 64'd9);
        chk({tag, "_W"}, 64'(W), 64'(exp));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_W_kept"}, 64'(W), 64'(exp));
    endtask

    initial begin
        #12;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_W", 64'(W), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        send("max_n",   28'd268435455, 1'b0, 1'b0, 6'd0,  36'd44828720985, 1'b0);
        send("pos35",   28'd0,         1'b1, 1'b0, 6'd35, 36'd34359738368, 1'b0);
        send("neg3",    28'd1,         1'b1, 1'b1, 6'd3,  36'd159,         1'b1);
        send("wrap",    28'd0,         1'b1, 1'b1, 6'd0,  36'd68719476735, 1'b0);
        send("pos40",   28'd0,         1'b1, 1'b1, 6'd40, 36'd0,           1'b0);
        send("mid_add", 28'h1234567,   1'b1, 1'b0, 6'd20, model(28'h1234567, 1'b1, 1'b0, 6'd20), 1'b1);
        send("mid_sub", 28'h0abcdef,   1'b1, 1'b1, 6'd31, model(28'h0abcdef, 1'b1, 1'b1, 6'd31), 1'b0);
        send("no_err",  28'd1000,      1'b0, 1'b1, 6'd7,  36'd167000,      1'b0);

        // backpressure: output held, a pulsed input word must not be accepted
        begin
            int k = 0;
            wait_ready("bp");
            N = 28'd2; err_en = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
            for (int i = 0; i < 5; i++) begin
                if (i == 2) begin N = 28'd5; in_valid = 1'b1; end
                else in_valid = 1'b0;
                @(posedge clk); #1;
                chk($sformatf("bp_ov%0d", i), 64'(out_valid), 64'd1);
                chk($sformatf("bp_W%0d", i), 64'(W), 64'd334);
                chk($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
            chk("bp_ov_drop", 64'(out_valid), 64'd0);
            chk("bp_idle", 64'(busy), 64'd0);
        end
        send("after_bp", 28'd7, 1'b0, 1'b0, 6'd0, 36'd1169, 1'b0);

        // asynchronous reset during the fourth multiply step discards the word
        wait_ready("rst_mid");
        N = 28'd9; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ov", 64'(out_valid), 64'd0);
        chk("rst_mid_W", 64'(W), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_mid_ov_after", 64'(out_valid), 64'd0);
        send("post_rst", 28'd3, 1'b0, 1'b0, 6'd0, 36'd501, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
